// File: rtl/skeeball_pkg.sv
// Shared types, constants and the ball-vector decode for the skee-ball game controller.
package skeeball_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_PLAYING = 2'd2,
      ST_OVER    = 2'd3
   } state_e;

   localparam int BALLS_W = 9;
   localparam int COUNT_W = 4;

   localparam logic [BALLS_W-1:0] BALLS_FULL    = 9'h1FF;
   localparam logic [BALLS_W-1:0] BALLS_EMPTY   = 9'h000;
   localparam logic [COUNT_W-1:0] COUNT_INVALID = 4'hF;

   // A legal code is a run of ones from bit 0 upward; adding one to such a code
   // clears every set bit, so any overlap between code and code+1 marks a broken vector.
   function automatic logic [COUNT_W-1:0] thermo_decode(input logic [BALLS_W-1:0] code);
      logic [BALLS_W:0]   plus_one;
      logic [COUNT_W-1:0] ones;
      plus_one = {1'b0, code} + {{BALLS_W{1'b0}}, 1'b1};
      ones     = '0;
      for (int i = 0; i < BALLS_W; i++) begin
         ones = ones + {{(COUNT_W-1){1'b0}}, code[i]};
      end
      if ((plus_one[BALLS_W-1:0] & code) != '0) begin
         return COUNT_INVALID;
      end
      return ones;
   endfunction

endpackage

// File: rtl/skeeball_debounce.sv
// Lane sensor conditioning: 2-flop synchroniser, stable-run debouncer, rising-edge strobe.
module skeeball_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sense_i,
   output logic rise_o
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_prev_q;
   logic [CNT_W-1:0] cnt_q;

   // Bring the asynchronous sensor into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sense_i;
         sync2_q <= sync1_q;
      end
   end

   // Flip the level only once the new value has been seen on every one of the last DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
      end else begin
         level_prev_q <= level_q;
         if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
               level_q <= sync2_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign rise_o = level_q & ~level_prev_q;

endmodule

// File: rtl/skeeball_game_ctrl.sv
// Game sequencer in front of the ball counter: arms the counter, turns debounced
// lane hits into ball-consumed strobes, and watches the returned ball vector.
//
//   state   | meaning
//   IDLE    | counter held in reload (game=0), waiting for start
//   ARM     | counter held in reload, waiting for a full rack (9'h1FF)
//   PLAYING | counter enabled; each accepted ball issues one strobe and awaits the decrement
//   OVER    | rack empty; counter kept enabled but never strobed so it cannot wrap back to 9
module skeeball_game_ctrl
   import skeeball_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ARM_TIMEOUT     = 8,
   parameter int ACK_TIMEOUT     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       ball_sense,
   input  logic [8:0] balls,
   output logic       game,
   output logic       ball_pulse,
   output logic [3:0] ball_count,
   output logic       game_over,
   output logic       code_err,
   output logic [1:0] state
);

   localparam int               TMO_MAX  = (ARM_TIMEOUT > ACK_TIMEOUT) ? ARM_TIMEOUT : ACK_TIMEOUT;
   localparam int               TMO_W    = $clog2(TMO_MAX + 1);
   localparam logic [TMO_W-1:0] ARM_LAST = TMO_W'(ARM_TIMEOUT - 1);
   localparam logic [TMO_W-1:0] ACK_LAST = TMO_W'(ACK_TIMEOUT - 1);

   state_e             state_q;
   logic               game_q;
   logic               ball_pulse_q;
   logic               game_over_q;
   logic               code_err_q;
   logic               pending_q;
   logic [COUNT_W-1:0] prev_q;
   logic [TMO_W-1:0]   tmo_q;

   logic               ball_evt;
   logic [COUNT_W-1:0] count;
   logic               code_bad;
   logic               count_live;

   skeeball_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .sense_i(ball_sense),
      .rise_o (ball_evt)
   );

   assign count      = thermo_decode(balls);
   assign code_bad   = (count == COUNT_INVALID);
   assign count_live = (count != '0) && (count <= 4'd9);

   // Sequencer with registered outputs; tmo_q is shared between the ARM wait and the decrement wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         game_q       <= 1'b0;
         ball_pulse_q <= 1'b0;
         game_over_q  <= 1'b0;
         code_err_q   <= 1'b0;
         pending_q    <= 1'b0;
         prev_q       <= '0;
         tmo_q        <= '0;
      end else begin
         ball_pulse_q <= 1'b0;
         if (code_bad) begin
            code_err_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_ARM;
                  code_err_q <= 1'b0;
                  tmo_q      <= '0;
               end
            end
            ST_ARM: begin
               if (balls == BALLS_FULL) begin
                  state_q <= ST_PLAYING;
                  game_q  <= 1'b1;
               end else if (tmo_q == ARM_LAST) begin
                  state_q    <= ST_IDLE;
                  code_err_q <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            ST_PLAYING: begin
               // While a strobe is outstanding any lane event is simply not looked at.
               if (pending_q) begin
                  if (count == prev_q - 4'd1) begin
                     pending_q <= 1'b0;
                  end else if ((count != prev_q) || (tmo_q == ACK_LAST)) begin
                     pending_q  <= 1'b0;
                     code_err_q <= 1'b1;
                  end else begin
                     tmo_q <= tmo_q + 1'b1;
                  end
               end else if (ball_evt && count_live) begin
                  ball_pulse_q <= 1'b1;
                  pending_q    <= 1'b1;
                  prev_q       <= count;
                  tmo_q        <= '0;
               end else if (balls == BALLS_EMPTY) begin
                  state_q     <= ST_OVER;
                  game_over_q <= 1'b1;
               end
            end
            ST_OVER: begin
               if (start) begin
                  state_q     <= ST_ARM;
                  game_q      <= 1'b0;
                  game_over_q <= 1'b0;
                  code_err_q  <= 1'b0;
                  tmo_q       <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               game_q  <= 1'b0;
            end
         endcase
      end
   end

   assign state      = state_q;
   assign game       = game_q;
   assign ball_pulse = ball_pulse_q;
   assign game_over  = game_over_q;
   assign code_err   = code_err_q;
   assign ball_count = count;

endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// Bench for skeeball_game_ctrl: behavioural game model compared every cycle,
// a bench-side ball counter, and directed scenarios with literal expectations.
module tb_skeeball_game_ctrl;

   localparam int DEB = 16;
   localparam int ARM_TMO = 8;
   localparam int ACK_TMO = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       ball_sense = 1'b0;
   logic [8:0] balls = 9'h1FF;
   logic       game;
   logic       ball_pulse;
   logic [3:0] ball_count;
   logic       game_over;
   logic       code_err;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int pulses_seen = 0;

   // bench counter: 0 = follows game/ball_pulse, 1 = frozen, 2 = forced to force_val
   int         ctr_mode = 0;
   logic [8:0] force_val = 9'h1FF;

   skeeball_game_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .ARM_TIMEOUT    (ARM_TMO),
      .ACK_TIMEOUT    (ACK_TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .ball_sense(ball_sense),
      .balls     (balls),
      .game      (game),
      .ball_pulse(ball_pulse),
      .ball_count(ball_count),
      .game_over (game_over),
      .code_err  (code_err),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_count(input logic [8:0] b);
      logic [8:0] pat;
      for (int j = 0; j <= 9; j++) begin
         pat = 9'((1 << j) - 1);
         if (b == pat) return j;
      end
      return 15;
   endfunction

   // Bench-side ball counter, updated shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      if (ctr_mode == 0) begin
         if (!game) balls = 9'h1FF;
         else if (ball_pulse) balls = (balls == 9'h000) ? 9'h1FF : (balls >> 1);
      end else if (ctr_mode == 2) begin
         balls = force_val;
      end
   end

   // ---------------- behavioural model ----------------
   bit m_sh0 = 0, m_sh1 = 0, m_lvl = 0, m_lvl_prev = 0;
   int m_run = 0;
   int m_st = 0;          // 0 idle, 1 arm, 2 playing, 3 over
   bit m_pulse = 0, m_err = 0, m_pend = 0;
   int m_prev = 0, m_wait = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sh0 = 0; m_sh1 = 0; m_lvl = 0; m_lvl_prev = 0; m_run = 0;
         m_st = 0; m_pulse = 0; m_err = 0; m_pend = 0; m_prev = 0; m_wait = 0;
      end else begin
         int cnt;
         bit evt;
         bit lvl_old;
         cnt = exp_count(balls);
         evt = m_lvl && !m_lvl_prev;
         m_pulse = 0;
         if (cnt == 15) m_err = 1;
         case (m_st)
            0: if (start) begin m_st = 1; m_err = 0; m_wait = 0; end
            1: begin
               if (balls == 9'h1FF) m_st = 2;
               else begin
                  m_wait++;
                  if (m_wait == ARM_TMO) begin m_err = 1; m_st = 0; end
               end
            end
            2: begin
               if (m_pend) begin
                  m_wait++;
                  if (cnt == m_prev - 1) m_pend = 0;
                  else if (cnt != m_prev || m_wait == ACK_TMO) begin m_pend = 0; m_err = 1; end
               end else if (evt && cnt >= 1 && cnt <= 9) begin
                  m_pulse = 1; m_pend = 1; m_prev = cnt; m_wait = 0;
               end else if (cnt == 0) begin
                  m_st = 3;
               end
            end
            default: if (start) begin m_st = 1; m_err = 0; m_wait = 0; end
         endcase
         lvl_old = m_lvl;
         if (m_sh1 != m_lvl) begin
            m_run++;
            if (m_run == DEB) begin m_lvl = m_sh1; m_run = 0; end
         end else begin
            m_run = 0;
         end
         m_lvl_prev = lvl_old;
         m_sh1 = m_sh0;
         m_sh0 = ball_sense;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("state", int'(state), m_st);
         chk("game", int'(game), (m_st >= 2) ? 1 : 0);
         chk("ball_pulse", int'(ball_pulse), int'(m_pulse));
         chk("game_over", int'(game_over), (m_st == 3) ? 1 : 0);
         chk("code_err", int'(code_err), int'(m_err));
         chk("ball_count", int'(ball_count), exp_count(balls));
         if (ball_pulse) pulses_seen++;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic ball(input int hi, input int lo);
      @(negedge clk);
      ball_sense = 1'b1;
      cycles(hi);
      ball_sense = 1'b0;
      cycles(lo);
   endtask

   initial begin
      int p0;
      cycles(3);
      chk("rst_state", int'(state), 0);
      chk("rst_game", int'(game), 0);
      chk("rst_pulse", int'(ball_pulse), 0);
      chk("rst_over", int'(game_over), 0);
      chk("rst_err", int'(code_err), 0);
      rst_n = 1'b1;
      cycles(2);
      chk("idle_count", int'(ball_count), 9);

      // start -> ARM -> PLAYING with a full rack
      press_start();
      chk("arm_state", int'(state), 1);
      cycles(2);
      chk("play_state", int'(state), 2);
      chk("play_game", int'(game), 1);
      chk("play_count", int'(ball_count), 9);
      chk("play_err", int'(code_err), 0);

      // 5-cycle glitch is filtered
      p0 = pulses_seen;
      ball(5, 25);
      chk("glitch_pulses", pulses_seen - p0, 0);
      chk("glitch_count", int'(ball_count), 9);

      // one clean ball
      ball(20, 25);
      chk("ball1_pulses", pulses_seen - p0, 1);
      chk("ball1_balls", int'(balls), 9'h0FF);
      chk("ball1_count", int'(ball_count), 8);

      // remaining eight balls empty the rack
      for (int i = 0; i < 8; i++) ball(20, 25);
      chk("nine_pulses", pulses_seen - p0, 9);
      chk("over_state", int'(state), 3);
      chk("over_flag", int'(game_over), 1);
      chk("over_game", int'(game), 1);

      // tenth ball in OVER is ignored
      ball(20, 25);
      chk("tenth_pulses", pulses_seen - p0, 9);
      chk("tenth_balls", int'(balls), 0);

      // restart from OVER
      press_start();
      cycles(3);
      chk("restart_state", int'(state), 2);
      chk("restart_count", int'(ball_count), 9);

      // counter ignores the strobe -> decrement wait expires
      ctr_mode = 1;
      p0 = pulses_seen;
      ball(20, 25);
      chk("ack_pulses", pulses_seen - p0, 1);
      chk("ack_err", int'(code_err), 1);
      chk("ack_count", int'(ball_count), 9);

      // invalid code while playing
      force_val = 9'b000010111;
      ctr_mode = 2;
      cycles(3);
      chk("bad_count", int'(ball_count), 15);
      chk("bad_err", int'(code_err), 1);
      chk("bad_state", int'(state), 2);
      force_val = 9'h1FF;
      cycles(2);
      ctr_mode = 0;

      // five balls, 9 -> 4
      for (int i = 0; i < 5; i++) ball(20, 25);
      chk("mid_count", int'(ball_count), 4);

      // asynchronous reset mid-game
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_state", int'(state), 0);
      chk("mrst_game", int'(game), 0);
      chk("mrst_pulse", int'(ball_pulse), 0);
      chk("mrst_over", int'(game_over), 0);
      chk("mrst_err", int'(code_err), 0);
      cycles(3);
      chk("mrst_reload", int'(balls), 9'h1FF);
      rst_n = 1'b1;

      // ARM never sees a full rack -> timeout back to IDLE with error
      force_val = 9'h000;
      ctr_mode = 2;
      cycles(2);
      press_start();
      cycles(12);
      chk("armtmo_state", int'(state), 0);
      chk("armtmo_err", int'(code_err), 1);

      // ARM entry clears the error, full rack -> PLAYING
      force_val = 9'h1FF;
      cycles(2);
      press_start();
      chk("rearm_err", int'(code_err), 0);
      cycles(2);
      chk("rearm_state", int'(state), 2);
      chk("rearm_game", int'(game), 1);
      ctr_mode = 0;
      cycles(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
